// File: rtl/apb_cmd_arb.sv
// rtl/apb_cmd_arb.sv - two-requester round-robin command arbiter for an APB command port
// Tracks outstanding reads in a tag FIFO so each read response goes back to the requester that issued it.
module apb_cmd_arb #(
  parameter int DATA_WD    = 4,
  parameter int ADDR_WD    = 4,
  parameter int OSTD_DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [DATA_WD+ADDR_WD:0]   req0_cmd,
  input  logic                       req0_vld,
  output logic                       req0_rdy,
  input  logic [DATA_WD+ADDR_WD:0]   req1_cmd,
  input  logic                       req1_vld,
  output logic                       req1_rdy,
  output logic [DATA_WD+ADDR_WD:0]   m_cmd,
  output logic                       m_vld,
  input  logic                       m_rdy,
  input  logic                       m_read_vld,
  input  logic [DATA_WD-1:0]         m_read_data,
  output logic                       rsp0_vld,
  output logic [DATA_WD-1:0]         rsp0_data,
  output logic                       rsp1_vld,
  output logic [DATA_WD-1:0]         rsp1_data,
  output logic                       err_unexp_rsp
);

  localparam int CW   = DATA_WD + ADDR_WD + 1;
  localparam int PW   = (OSTD_DEPTH > 1) ? $clog2(OSTD_DEPTH) : 1;
  localparam int CNTW = $clog2(OSTD_DEPTH) + 1;
  localparam logic [CNTW-1:0] FULL_CNT = CNTW'(OSTD_DEPTH);

  logic                  last_grant;
  logic [OSTD_DEPTH-1:0] tag_q;
  logic [PW-1:0]         wr_ptr;
  logic [PW-1:0]         rd_ptr;
  logic [CNTW-1:0]       cnt;

  logic          slot_free;
  logic          can_read;
  logic          elig0;
  logic          elig1;
  logic          gnt_vld;
  logic          gnt_id;
  logic [CW-1:0] gnt_cmd;
  logic          push;
  logic          pop;
  logic          head_id;

  // Read eligibility looks only at the count before this cycle, so a same-cycle pop never frees a slot early.
  always_comb begin
    slot_free = !m_vld || m_rdy;
    can_read  = cnt < FULL_CNT;
    elig0     = req0_vld && (req0_cmd[CW-1] || can_read);
    elig1     = req1_vld && (req1_cmd[CW-1] || can_read);
    gnt_vld   = rst_n && slot_free && (elig0 || elig1);
    gnt_id    = (elig0 && elig1) ? ~last_grant : elig1;
    gnt_cmd   = gnt_id ? req1_cmd : req0_cmd;
    push      = gnt_vld && !gnt_cmd[CW-1];
    pop       = rst_n && m_read_vld && (cnt != '0);
    head_id   = tag_q[rd_ptr];
  end

  assign req0_rdy  = gnt_vld && !gnt_id;
  assign req1_rdy  = gnt_vld && gnt_id;
  assign rsp0_vld  = pop && !head_id;
  assign rsp1_vld  = pop && head_id;
  assign rsp0_data = m_read_data;
  assign rsp1_data = m_read_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_cmd         <= '0;
      m_vld         <= 1'b0;
      last_grant    <= 1'b1;
      tag_q         <= '0;
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      cnt           <= '0;
      err_unexp_rsp <= 1'b0;
    end else begin
      if (slot_free) begin
        m_vld <= gnt_vld;
        if (gnt_vld) begin
          m_cmd      <= gnt_cmd;
          last_grant <= gnt_id;
        end
      end
      if (push) begin
        tag_q[wr_ptr] <= gnt_id;
        wr_ptr        <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      if (push && !pop) begin
        cnt <= cnt + CNTW'(1);
      end else if (pop && !push) begin
        cnt <= cnt - CNTW'(1);
      end
      if (m_read_vld && (cnt == '0)) begin
        err_unexp_rsp <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_apb_cmd_arb.sv
// tb/tb_apb_cmd_arb.sv - directed self-checking bench for apb_cmd_arb
// Inputs change on the falling edge; outputs are sampled on the falling edge or 1ns after it.
module tb_apb_cmd_arb;

  logic       clk;
  logic       rst_n;
  logic [8:0] req0_cmd;
  logic       req0_vld;
  logic       req0_rdy;
  logic [8:0] req1_cmd;
  logic       req1_vld;
  logic       req1_rdy;
  logic [8:0] m_cmd;
  logic       m_vld;
  logic       m_rdy;
  logic       m_read_vld;
  logic [3:0] m_read_data;
  logic       rsp0_vld;
  logic [3:0] rsp0_data;
  logic       rsp1_vld;
  logic [3:0] rsp1_data;
  logic       err_unexp_rsp;

  int n_checks;
  int n_fail;
  logic g;

  apb_cmd_arb #(.DATA_WD(4), .ADDR_WD(4), .OSTD_DEPTH(4)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req0_cmd     (req0_cmd),
    .req0_vld     (req0_vld),
    .req0_rdy     (req0_rdy),
    .req1_cmd     (req1_cmd),
    .req1_vld     (req1_vld),
    .req1_rdy     (req1_rdy),
    .m_cmd        (m_cmd),
    .m_vld        (m_vld),
    .m_rdy        (m_rdy),
    .m_read_vld   (m_read_vld),
    .m_read_data  (m_read_data),
    .rsp0_vld     (rsp0_vld),
    .rsp0_data    (rsp0_data),
    .rsp1_vld     (rsp1_vld),
    .rsp1_data    (rsp1_data),
    .err_unexp_rsp(err_unexp_rsp)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail = 0;
    clk = 1'b0;
    rst_n = 1'b0;
    req0_cmd = 9'h135;
    req0_vld = 1'b1;
    req1_cmd = 9'h000;
    req1_vld = 1'b0;
    m_rdy = 1'b1;
    m_read_vld = 1'b1;
    m_read_data = 4'h0;

    // reset state, with a request and a response pending
    repeat (2) @(negedge clk);
    #1;
    chk("rst_m_vld", 32'(m_vld), 32'h0);
    chk("rst_m_cmd", 32'(m_cmd), 32'h0);
    chk("rst_err", 32'(err_unexp_rsp), 32'h0);
    chk("rst_req0_rdy", 32'(req0_rdy), 32'h0);
    chk("rst_rsp0_vld", 32'(rsp0_vld), 32'h0);
    chk("rst_rsp1_vld", 32'(rsp1_vld), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    req0_vld = 1'b0;
    m_read_vld = 1'b0;

    // single write
    @(negedge clk);
    req0_cmd = 9'h135;
    req0_vld = 1'b1;
    #1;
    chk("wr_req0_rdy", 32'(req0_rdy), 32'h1);
    chk("wr_req1_rdy", 32'(req1_rdy), 32'h0);
    @(negedge clk);
    chk("wr_m_vld", 32'(m_vld), 32'h1);
    chk("wr_m_cmd", 32'(m_cmd), 32'h135);
    req0_vld = 1'b0;
    @(negedge clk);
    chk("wr_idle_m_vld", 32'(m_vld), 32'h0);

    // contention: req0 won last, so req1 takes the first tie
    req0_cmd = 9'h111;
    req1_cmd = 9'h122;
    req0_vld = 1'b1;
    req1_vld = 1'b1;
    g = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("rr_req0_rdy", 32'(req0_rdy), 32'(!g));
      chk("rr_req1_rdy", 32'(req1_rdy), 32'(g));
      @(negedge clk);
      chk("rr_m_vld", 32'(m_vld), 32'h1);
      chk("rr_m_cmd", 32'(m_cmd), g ? 32'h122 : 32'h111);
      g = ~g;
    end

    // stall for 3 cycles
    m_rdy = 1'b0;
    #1;
    chk("stall_req0_rdy", 32'(req0_rdy), 32'h0);
    chk("stall_req1_rdy", 32'(req1_rdy), 32'h0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("stall_m_cmd", 32'(m_cmd), 32'h111);
      chk("stall_m_vld", 32'(m_vld), 32'h1);
      chk("stall_rdy0", 32'(req0_rdy), 32'h0);
      chk("stall_rdy1", 32'(req1_rdy), 32'h0);
    end
    m_rdy = 1'b1;
    #1;
    chk("unstall_req1_rdy", 32'(req1_rdy), 32'h1);
    chk("unstall_req0_rdy", 32'(req0_rdy), 32'h0);
    @(negedge clk);
    chk("unstall_m_cmd", 32'(m_cmd), 32'h122);
    req0_vld = 1'b0;
    req1_vld = 1'b0;
    @(negedge clk);
    chk("drain_m_vld", 32'(m_vld), 32'h0);

    // read routing
    req1_cmd = 9'h020;
    req1_vld = 1'b1;
    #1;
    chk("rd1_req1_rdy", 32'(req1_rdy), 32'h1);
    @(negedge clk);
    req1_vld = 1'b0;
    req0_cmd = 9'h070;
    req0_vld = 1'b1;
    #1;
    chk("rd0_req0_rdy", 32'(req0_rdy), 32'h1);
    chk("rd1_m_cmd", 32'(m_cmd), 32'h020);
    @(negedge clk);
    req0_vld = 1'b0;
    chk("rd0_m_cmd", 32'(m_cmd), 32'h070);
    m_read_vld = 1'b1;
    m_read_data = 4'hA;
    #1;
    chk("rsp_a_rsp1_vld", 32'(rsp1_vld), 32'h1);
    chk("rsp_a_rsp0_vld", 32'(rsp0_vld), 32'h0);
    chk("rsp_a_rsp1_data", 32'(rsp1_data), 32'hA);
    @(negedge clk);
    m_read_data = 4'hB;
    #1;
    chk("rsp_b_rsp0_vld", 32'(rsp0_vld), 32'h1);
    chk("rsp_b_rsp1_vld", 32'(rsp1_vld), 32'h0);
    chk("rsp_b_rsp0_data", 32'(rsp0_data), 32'hB);
    chk("rsp_b_rsp1_data", 32'(rsp1_data), 32'hB);
    @(negedge clk);
    m_read_vld = 1'b0;
    #1;
    chk("rsp_err_clear", 32'(err_unexp_rsp), 32'h0);

    // fill the tag FIFO with 4 reads from req0
    @(negedge clk);
    req0_cmd = 9'h030;
    req0_vld = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("fill_req0_rdy", 32'(req0_rdy), 32'h1);
      @(negedge clk);
    end
    req1_cmd = 9'h1A5;
    req1_vld = 1'b1;
    #1;
    chk("full_req0_rdy", 32'(req0_rdy), 32'h0);
    chk("full_req1_rdy", 32'(req1_rdy), 32'h1);
    @(negedge clk);
    req1_vld = 1'b0;
    chk("full_m_cmd", 32'(m_cmd), 32'h1A5);
    m_read_vld = 1'b1;
    m_read_data = 4'hC;
    #1;
    chk("full_rsp0_vld", 32'(rsp0_vld), 32'h1);
    chk("full_no_bypass", 32'(req0_rdy), 32'h0);
    @(negedge clk);
    m_read_vld = 1'b0;
    #1;
    chk("full_pop_req0_rdy", 32'(req0_rdy), 32'h1);
    @(negedge clk);
    req0_vld = 1'b0;
    chk("full_m_cmd_rd", 32'(m_cmd), 32'h030);

    // drain 4 tags, then one unexpected response
    m_read_vld = 1'b1;
    m_read_data = 4'h5;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("drain_rsp0_vld", 32'(rsp0_vld), 32'h1);
      @(negedge clk);
    end
    #1;
    chk("unexp_rsp0_vld", 32'(rsp0_vld), 32'h0);
    chk("unexp_rsp1_vld", 32'(rsp1_vld), 32'h0);
    chk("unexp_err_pre", 32'(err_unexp_rsp), 32'h0);
    @(negedge clk);
    m_read_vld = 1'b0;
    chk("unexp_err", 32'(err_unexp_rsp), 32'h1);
    @(negedge clk);
    chk("unexp_err_sticky", 32'(err_unexp_rsp), 32'h1);

    // reset pulse mid-traffic
    m_rdy = 1'b0;
    req0_cmd = 9'h1FF;
    req0_vld = 1'b1;
    @(negedge clk);
    chk("mid_m_vld", 32'(m_vld), 32'h1);
    rst_n = 1'b0;
    m_read_vld = 1'b1;
    #1;
    chk("mid_rst_m_vld", 32'(m_vld), 32'h0);
    chk("mid_rst_m_cmd", 32'(m_cmd), 32'h0);
    chk("mid_rst_err", 32'(err_unexp_rsp), 32'h0);
    chk("mid_rst_req0_rdy", 32'(req0_rdy), 32'h0);
    chk("mid_rst_rsp0_vld", 32'(rsp0_vld), 32'h0);
    chk("mid_rst_rsp1_vld", 32'(rsp1_vld), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    m_read_vld = 1'b0;
    m_rdy = 1'b1;
    req1_cmd = 9'h1EE;
    req1_vld = 1'b1;
    #1;
    chk("post_rst_req0_rdy", 32'(req0_rdy), 32'h1);
    chk("post_rst_req1_rdy", 32'(req1_rdy), 32'h0);
    @(negedge clk);
    chk("post_rst_m_cmd", 32'(m_cmd), 32'h1FF);
    req0_vld = 1'b0;
    req1_vld = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
